// File: rtl/ex_stage_mc_pkg.sv
// Shared types and constants for the multi-cycle execute stage.
package ex_stage_mc_pkg;

    typedef enum logic [2:0] {
        ALU_PASS_B = 3'b000,
        ALU_ADD    = 3'b010,
        ALU_SUB    = 3'b011,
        ALU_AND    = 3'b100,
        ALU_OR     = 3'b101,
        ALU_XOR    = 3'b110
    } alu_ctrl_t;

    localparam int FLAG_N = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_C = 3;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } ex_mul_state_t;

endpackage

// File: rtl/ex_stage_mc_iter_multiplier.sv
// Iterative shift-add multiplier retiring BITS_PER_CYCLE multiplier bits per cycle.
// Only the low WIDTH bits of the product are kept, so signedness does not matter.
module iter_multiplier #(
    parameter int WIDTH          = 64,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int L  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = $clog2(L + 1);

    logic [WIDTH-1:0] mcand_q, mplier_q, acc_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] partial;

    // NOTE: give every combinational output a default first so no path can infer a latch.
    always_comb begin
        partial = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mplier_q[i]) partial = partial + (mcand_q << i);
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
        end else if (start) begin
            mcand_q  <= a;
            mplier_q <= b;
            acc_q    <= '0;
            count_q  <= CW'(L);
        end else if (count_q != '0) begin
            acc_q    <= acc_q + partial;
            mcand_q  <= mcand_q << BITS_PER_CYCLE;
            mplier_q <= mplier_q >> BITS_PER_CYCLE;
            count_q  <= count_q - CW'(1);
        end
    end

    assign busy    = (count_q != '0);
    assign done    = (count_q == CW'(1));
    assign product = acc_q;

endmodule

// File: rtl/ex_stage_mc.sv
// Execute stage: forwarding muxes, ALU with NZVC flags, and a stalling iterative MUL.
module ex_stage_mc
    import ex_stage_mc_pkg::*;
#(
    parameter int WIDTH          = 64,
    parameter int REG_BITS       = 5,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [2:0]          alu_ctrl,
    input  logic                is_mul,
    input  logic                alu_src,
    input  logic                set_flags,
    input  logic [WIDTH-1:0]    read_data_1,
    input  logic [WIDTH-1:0]    read_data_2,
    input  logic [WIDTH-1:0]    imm,
    input  logic [REG_BITS-1:0] rn,
    input  logic [REG_BITS-1:0] rm,
    input  logic [REG_BITS-1:0] mem_rd,
    input  logic [REG_BITS-1:0] wb_rd,
    input  logic                mem_reg_write,
    input  logic                wb_reg_write,
    input  logic [WIDTH-1:0]    mem_alu_result,
    input  logic [WIDTH-1:0]    wb_write_data,
    output logic [WIDTH-1:0]    result,
    output logic [WIDTH-1:0]    alu_b,
    output logic                result_valid,
    output logic                stall,
    output logic [3:0]          temp_flags,
    output logic [3:0]          flags
);

    localparam logic [REG_BITS-1:0] XZR = '1;

    ex_mul_state_t    state_q;
    logic [3:0]       flags_q;
    logic [WIDTH-1:0] fwd_a, fwd_b, op_b, addend, alu_out, product;
    logic [WIDTH:0]   sum;
    logic             carry, ovf, sub_op, mul_start, mul_busy, mul_done;
    alu_ctrl_t        op;

    // MEM is the younger producer, so it wins over WB; XZR is never forwarded.
    always_comb begin
        fwd_a = read_data_1;
        if (rn != XZR && mem_reg_write && mem_rd == rn)    fwd_a = mem_alu_result;
        else if (rn != XZR && wb_reg_write && wb_rd == rn) fwd_a = wb_write_data;
    end

    always_comb begin
        fwd_b = read_data_2;
        if (rm != XZR && mem_reg_write && mem_rd == rm)    fwd_b = mem_alu_result;
        else if (rm != XZR && wb_reg_write && wb_rd == rm) fwd_b = wb_write_data;
    end

    assign alu_b = fwd_b;
    assign op_b  = alu_src ? imm : fwd_b;
    assign op    = alu_ctrl_t'(alu_ctrl);

    // Subtract is A + ~B + 1, so the adder carry is already the "no borrow" C flag.
    always_comb begin
        sub_op  = (op == ALU_SUB);
        addend  = sub_op ? ~op_b : op_b;
        sum     = {1'b0, fwd_a} + {1'b0, addend} + (WIDTH + 1)'(sub_op);
        alu_out = '0;
        carry   = 1'b0;
        ovf     = 1'b0;
        case (op)
            ALU_PASS_B: alu_out = op_b;
            ALU_ADD, ALU_SUB: begin
                alu_out = sum[WIDTH-1:0];
                carry   = sum[WIDTH];
                ovf     = (fwd_a[WIDTH-1] == addend[WIDTH-1]) &&
                          (sum[WIDTH-1] != fwd_a[WIDTH-1]);
            end
            ALU_AND:    alu_out = fwd_a & op_b;
            ALU_OR:     alu_out = fwd_a | op_b;
            ALU_XOR:    alu_out = fwd_a ^ op_b;
            default:    alu_out = '0;
        endcase
        temp_flags         = '0;
        temp_flags[FLAG_N] = alu_out[WIDTH-1];
        temp_flags[FLAG_Z] = (alu_out == '0);
        temp_flags[FLAG_V] = ovf;
        temp_flags[FLAG_C] = carry;
    end

    assign mul_start = rst && (state_q == IDLE) && in_valid && is_mul;

    iter_multiplier #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (fwd_a),
        .b       (fwd_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (product)
    );

    // DONE always returns to IDLE so the still-held MUL is not accepted twice.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            flags_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && is_mul)         state_q <= BUSY;
                    else if (in_valid && set_flags) flags_q <= temp_flags;
                end
                BUSY:    if (mul_done) state_q <= DONE;
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        result       = alu_out;
        result_valid = 1'b0;
        stall        = 1'b0;
        if (rst) begin
            case (state_q)
                IDLE: begin
                    result_valid = in_valid && !is_mul;
                    stall        = mul_start;
                end
                BUSY: stall = mul_busy;
                DONE: begin
                    result       = product;
                    result_valid = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign flags = flags_q;

endmodule

// File: tb/tb_ex_stage_mc.sv
// Randomised self-checking bench for ex_stage_mc against an arithmetic reference model.
module tb_ex_stage_mc;

    localparam int WIDTH          = 64;
    localparam int REG_BITS       = 5;
    localparam int BITS_PER_CYCLE = 1;
    localparam int L              = WIDTH / BITS_PER_CYCLE;
    localparam logic [REG_BITS-1:0] XZR = '1;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid, is_mul, alu_src, set_flags;
    logic                mem_reg_write, wb_reg_write;
    logic [2:0]          alu_ctrl;
    logic [WIDTH-1:0]    read_data_1, read_data_2, imm, mem_alu_result, wb_write_data;
    logic [REG_BITS-1:0] rn, rm, mem_rd, wb_rd;
    logic [WIDTH-1:0]    result, alu_b;
    logic                result_valid, stall;
    logic [3:0]          temp_flags, flags;

    int         checks    = 0;
    int         passed    = 0;
    logic [3:0] exp_flags = '0;

    logic [2:0]          ops  [6] = '{3'b000, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110};
    logic [REG_BITS-1:0] regs [3] = '{5'd3, 5'd7, 5'd31};

    always #5 clk = ~clk;

    ex_stage_mc #(
        .WIDTH(WIDTH), .REG_BITS(REG_BITS), .BITS_PER_CYCLE(BITS_PER_CYCLE)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .alu_ctrl(alu_ctrl), .is_mul(is_mul),
        .alu_src(alu_src), .set_flags(set_flags), .read_data_1(read_data_1),
        .read_data_2(read_data_2), .imm(imm), .rn(rn), .rm(rm), .mem_rd(mem_rd),
        .wb_rd(wb_rd), .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
        .mem_alu_result(mem_alu_result), .wb_write_data(wb_write_data), .result(result),
        .alu_b(alu_b), .result_valid(result_valid), .stall(stall),
        .temp_flags(temp_flags), .flags(flags)
    );

    function automatic logic [WIDTH-1:0] ref_fwd(
        input logic [REG_BITS-1:0] src, input logic [WIDTH-1:0] rf,
        input logic [REG_BITS-1:0] mrd, input logic mw, input logic [WIDTH-1:0] mv,
        input logic [REG_BITS-1:0] wrd, input logic ww, input logic [WIDTH-1:0] wv);
        if (src == XZR)            return rf;
        if (mw && mrd == src)      return mv;
        if (ww && wrd == src)      return wv;
        return rf;
    endfunction

    // Flags from plain arithmetic: wide unsigned sums for C, wide signed sums for V.
    task automatic ref_alu(input logic [2:0] ctrl, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, output logic [WIDTH-1:0] res,
                           output logic [3:0] f);
        logic signed [WIDTH+1:0] sa, sb, sr, smax, smin;
        logic c, v;
        sa   = $signed(a);
        sb   = $signed(b);
        smax = {3'b000, {(WIDTH-1){1'b1}}};
        smin = ~smax;
        c    = 1'b0;
        v    = 1'b0;
        case (ctrl)
            3'b000: res = b;
            3'b010: begin
                res = a + b;
                c   = ({1'b0, a} + {1'b0, b}) > {1'b0, {WIDTH{1'b1}}};
                sr  = sa + sb;
                v   = (sr > smax) || (sr < smin);
            end
            3'b011: begin
                res = a - b;
                c   = (a >= b);
                sr  = sa - sb;
                v   = (sr > smax) || (sr < smin);
            end
            3'b100:  res = a & b;
            3'b101:  res = a | b;
            3'b110:  res = a ^ b;
            default: res = '0;
        endcase
        f = {c, v, (res == '0), res[WIDTH-1]};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic v, input logic [2:0] ctrl, input logic m, input logic src,
                          input logic sf, input logic [WIDTH-1:0] r1, input logic [WIDTH-1:0] r2,
                          input logic [WIDTH-1:0] im, input logic [REG_BITS-1:0] n,
                          input logic [REG_BITS-1:0] mm);
        in_valid = v; alu_ctrl = ctrl; is_mul = m; alu_src = src; set_flags = sf;
        read_data_1 = r1; read_data_2 = r2; imm = im; rn = n; rm = mm;
    endtask

    task automatic set_fwd(input logic [REG_BITS-1:0] mrd, input logic mw,
                           input logic [WIDTH-1:0] mv, input logic [REG_BITS-1:0] wrd,
                           input logic ww, input logic [WIDTH-1:0] wv);
        mem_rd = mrd; mem_reg_write = mw; mem_alu_result = mv;
        wb_rd = wrd; wb_reg_write = ww; wb_write_data = wv;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_fwd(0, 0, 0, 0, 0, 0);
        set_op(1, 3'b010, 0, 0, 1, 64'h12, 64'h34, 64'h0, 5'd1, 5'd2);
        #2;
        checks++; if (stall !== 1'b0 || result_valid !== 1'b0) $display("FAIL reset_ctrl: stall/valid %b%b need 00", stall, result_valid); else passed++;
        checks++; if (result !== 64'h46) $display("FAIL reset_result: got %h need 46", result); else passed++;
        step(); step();
        checks++; if (flags !== 4'b0000) $display("FAIL reset_flags: got %b need 0000", flags); else passed++;
        rst = 1'b1;
        exp_flags = 4'b0000;
        step();
    endtask

    task automatic test_forwarding();
        logic [WIDTH-1:0] fa, fb, er;
        logic [3:0] ef;
        set_fwd(5'd3, 1, 64'h10, 5'd3, 1, 64'h20);
        set_op(1, 3'b010, 0, 1, 0, 64'h30, 64'h0, 64'h1, 5'd3, 5'd0);
        #2;
        checks++; if (result !== 64'h11 || result_valid !== 1'b1) $display("FAIL fwd_mem_priority: got %h/%b need 11/1", result, result_valid); else passed++;
        step();
        mem_reg_write = 1'b0;
        #2;
        checks++; if (result !== 64'h21) $display("FAIL fwd_wb: got %h need 21", result); else passed++;
        step();
        for (int i = 0; i < 24; i++) begin
            set_fwd(regs[$urandom_range(0, 2)], 1'($urandom), {$urandom, $urandom},
                    regs[$urandom_range(0, 2)], 1'($urandom), {$urandom, $urandom});
            set_op(1, ops[$urandom_range(0, 5)], 0, 1'($urandom), 0, {$urandom, $urandom},
                   {$urandom, $urandom}, {$urandom, $urandom},
                   regs[$urandom_range(0, 2)], regs[$urandom_range(0, 2)]);
            fa = ref_fwd(rn, read_data_1, mem_rd, mem_reg_write, mem_alu_result, wb_rd, wb_reg_write, wb_write_data);
            fb = ref_fwd(rm, read_data_2, mem_rd, mem_reg_write, mem_alu_result, wb_rd, wb_reg_write, wb_write_data);
            ref_alu(alu_ctrl, fa, alu_src ? imm : fb, er, ef);
            #2;
            checks++; if (result !== er || result_valid !== 1'b1) $display("FAIL fwd_rand_result[%0d]: got %h/%b need %h/1", i, result, result_valid, er); else passed++;
            checks++; if (alu_b !== fb) $display("FAIL fwd_rand_alu_b[%0d]: got %h need %h", i, alu_b, fb); else passed++;
            step();
        end
    endtask

    task automatic test_xzr();
        set_fwd(5'd31, 1, 64'hDEAD, 5'd31, 1, 64'hBEEF);
        set_op(1, 3'b010, 0, 1, 0, 64'h0, 64'h77, 64'h5, 5'd31, 5'd31);
        #2;
        checks++; if (result !== 64'h5) $display("FAIL xzr_a: got %h need 5", result); else passed++;
        checks++; if (alu_b !== 64'h77) $display("FAIL xzr_b: got %h need 77", alu_b); else passed++;
        step();
    endtask

    task automatic test_flags();
        logic [WIDTH-1:0] a, b, er;
        logic [3:0] ef;
        logic v, sf;
        logic [2:0] op;
        set_fwd(0, 0, 0, 0, 0, 0);
        set_op(1, 3'b011, 0, 1, 1, 64'h5, 64'h0, 64'h5, 5'd1, 5'd2);
        #2;
        checks++; if (temp_flags !== 4'b1010 || result !== 64'h0) $display("FAIL sub_eq_temp: got %b/%h need 1010/0", temp_flags, result); else passed++;
        step();
        exp_flags = 4'b1010;
        checks++; if (flags !== 4'b1010) $display("FAIL sub_eq_flags: got %b need 1010", flags); else passed++;
        set_op(1, 3'b010, 0, 1, 0, 64'h1, 64'h0, 64'h1, 5'd1, 5'd2);
        step();
        checks++; if (flags !== 4'b1010) $display("FAIL flags_hold: got %b need 1010", flags); else passed++;
        for (int i = 0; i < 20; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            sf = 1'($urandom);
            op = ops[$urandom_range(0, 5)];
            a  = $urandom_range(0, 1) ? {$urandom, $urandom} : 64'($urandom_range(0, 3));
            b  = (i % 4 == 0) ? a : ($urandom_range(0, 1) ? {$urandom, $urandom} : 64'($urandom_range(0, 3)));
            set_op(v, op, 0, 1, sf, a, 64'h0, b, 5'd1, 5'd2);
            ref_alu(op, a, b, er, ef);
            #2;
            checks++; if (temp_flags !== ef || result !== er || result_valid !== v) $display("FAIL flags_rand_temp[%0d]: got %b/%h/%b need %b/%h/%b", i, temp_flags, result, result_valid, ef, er, v); else passed++;
            if (v && sf) exp_flags = ef;
            step();
            checks++; if (flags !== exp_flags) $display("FAIL flags_rand_reg[%0d]: got %b need %b", i, flags, exp_flags); else passed++;
        end
    endtask

    task automatic test_overflow();
        set_fwd(0, 0, 0, 0, 0, 0);
        set_op(1, 3'b010, 0, 1, 1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 64'h1, 5'd1, 5'd2);
        #2;
        checks++; if (temp_flags !== 4'b0101 || result !== 64'h8000_0000_0000_0000) $display("FAIL ovf_temp: got %b/%h need 0101/8000000000000000", temp_flags, result); else passed++;
        step();
        exp_flags = 4'b0101;
        checks++; if (flags !== 4'b0101) $display("FAIL ovf_flags: got %b need 0101", flags); else passed++;
    endtask

    task automatic test_mul();
        logic [WIDTH-1:0] a, b, er;
        logic [3:0] ef;
        int bad;
        set_fwd(0, 0, 0, 0, 0, 0);
        set_op(1, 3'b010, 1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h3, 64'h0, 5'd1, 5'd2);
        #2;
        checks++; if (stall !== 1'b1 || result_valid !== 1'b0) $display("FAIL mul_accept: stall/valid %b%b need 10", stall, result_valid); else passed++;
        bad = 0;
        for (int k = 1; k <= L; k++) begin
            step(); #2;
            if (stall !== 1'b1 || result_valid !== 1'b0) bad++;
        end
        checks++; if (bad != 0) $display("FAIL mul_busy_stall: %0d bad cycles need 0", bad); else passed++;
        step(); #2;
        checks++; if (result_valid !== 1'b1 || stall !== 1'b0 || result !== 64'hFFFF_FFFF_FFFF_FFFD) $display("FAIL mul_done: got %h v%b s%b need fffffffffffffffd v1 s0", result, result_valid, stall); else passed++;
        checks++; if (flags !== exp_flags) $display("FAIL mul_flags: got %b need %b", flags, exp_flags); else passed++;
        step();
        set_op(1, 3'b010, 0, 1, 0, 64'h9, 64'h0, 64'h4, 5'd1, 5'd2);
        #2;
        checks++; if (stall !== 1'b0 || result_valid !== 1'b1 || result !== 64'hD) $display("FAIL mul_no_reaccept: got %h v%b s%b need d v1 s0", result, result_valid, stall); else passed++;
        step();
        // Operands come through forwarding and the sources are scrambled while busy.
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        set_fwd(5'd3, 1, a, 5'd7, 1, b);
        set_op(1, 3'b000, 1, 0, 0, {$urandom, $urandom}, {$urandom, $urandom}, 64'h0, 5'd3, 5'd7);
        for (int k = 1; k <= L; k++) begin
            step();
            set_fwd(5'd3, 1, {$urandom, $urandom}, 5'd7, 1, {$urandom, $urandom});
            read_data_1 = {$urandom, $urandom};
        end
        step(); #2;
        er = a * b;
        checks++; if (result_valid !== 1'b1 || result !== er) $display("FAIL mul_latched: got %h v%b need %h v1", result, result_valid, er); else passed++;
        ref_alu(3'b000, 0, 0, er, ef);
        step();
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] a1, b1, a2, b2, p;
        set_fwd(0, 0, 0, 0, 0, 0);
        a1 = {$urandom, $urandom}; b1 = {$urandom, $urandom};
        a2 = {$urandom, $urandom}; b2 = 64'($urandom);
        set_op(1, 3'b010, 1, 0, 0, a1, b1, 64'h0, 5'd1, 5'd2);
        repeat (L + 1) step();
        #2;
        p = a1 * b1;
        checks++; if (result_valid !== 1'b1 || result !== p) $display("FAIL b2b_first: got %h v%b need %h v1", result, result_valid, p); else passed++;
        step();
        set_op(1, 3'b010, 1, 0, 0, a2, b2, 64'h0, 5'd1, 5'd2);
        #2;
        checks++; if (stall !== 1'b1 || result_valid !== 1'b0) $display("FAIL b2b_accept: stall/valid %b%b need 10", stall, result_valid); else passed++;
        repeat (L) step();
        #2;
        checks++; if (stall !== 1'b1) $display("FAIL b2b_last_busy: stall %b need 1", stall); else passed++;
        step(); #2;
        p = a2 * b2;
        checks++; if (result_valid !== 1'b1 || result !== p) $display("FAIL b2b_second: got %h v%b need %h v1", result, result_valid, p); else passed++;
        step();
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_mul();
        logic [WIDTH-1:0] er;
        logic [3:0] ef;
        set_fwd(0, 0, 0, 0, 0, 0);
        set_op(1, 3'b010, 1, 0, 0, 64'h1234, 64'h10, 64'h0, 5'd1, 5'd2);
        repeat (20) step();
        rst = 1'b0;
        #1;
        checks++; if (stall !== 1'b0 || result_valid !== 1'b0 || result !== 64'h1244) $display("FAIL rst_mid_mul: got %h v%b s%b need 1244 v0 s0", result, result_valid, stall); else passed++;
        checks++; if (flags !== 4'b0000) $display("FAIL rst_mid_flags: got %b need 0000", flags); else passed++;
        exp_flags = 4'b0000;
        step();
        rst = 1'b1;
        set_op(1, 3'b010, 0, 1, 1, 64'h20, 64'h0, 64'h22, 5'd1, 5'd2);
        ref_alu(3'b010, 64'h20, 64'h22, er, ef);
        #2;
        checks++; if (stall !== 1'b0 || result_valid !== 1'b1 || result !== er) $display("FAIL rst_after_add: got %h v%b s%b need %h v1 s0", result, result_valid, stall, er); else passed++;
        step();
        exp_flags = ef;
        checks++; if (flags !== exp_flags) $display("FAIL rst_after_flags: got %b need %b", flags, exp_flags); else passed++;
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_xzr();
        test_flags();
        test_overflow();
        test_mul();
        test_back_to_back();
        test_reset_mid_mul();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/ex_stage_mc.md
# ex_stage_mc

Parametrised execute stage for the pipelined ARM core. It has a WIDTH-bit ALU, operand forwarding from the MEM and WB stages, and an architectural NZVC flag register. It also adds an iterative multi-cycle multiplier that stalls the front of the pipeline while it runs. It sits between the ID/EX and EX/MEM pipeline registers.

## Interface
Parameters:
- WIDTH, 64, datapath width; multiple of BITS_PER_CYCLE
- REG_BITS, 5, register index width; index all-ones is XZR
- BITS_PER_CYCLE, 1, multiplier bits retired per cycle; L = WIDTH/BITS_PER_CYCLE

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  ID/EX holds a valid instruction
- alu_ctrl  in  3  000 pass B, 010 add, 011 sub, 100 and, 101 or, 110 xor
- is_mul  in  1  instruction is MUL (alu_ctrl ignored)
- alu_src  in  1  1: B operand = imm
- set_flags  in  1  update NZVC
- read_data_1, read_data_2, imm  in  WIDTH each  operands from ID/EX
- rn, rm  in  REG_BITS each  source register indices
- mem_rd, wb_rd  in  REG_BITS each  destination indices in MEM, WB
- mem_reg_write, wb_reg_write  in  1 each  destination will be written
- mem_alu_result, wb_write_data  in  WIDTH each  forwarding data
- result  out  WIDTH  ALU result or product
- alu_b  out  WIDTH  forwarded B before imm mux (store data)
- result_valid  out  1  result is valid this cycle
- stall  out  1  hold PC, IF/ID and ID/EX; EX/MEM captures a bubble
- temp_flags  out  4  combinational {C,V,Z,N} of this cycle's ALU op
- flags  out  4  registered {C,V,Z,N}: [0]=N, [1]=Z, [2]=V, [3]=C

## Operation
- Forwarding, per operand (A uses rn, B uses rm):
  - MEM match (reg_write && rd == src && src != all-ones) has priority over WB match.
  - Otherwise the register-file value is used.
- ALU:
  - add/sub are WIDTH-bit two's complement.
  - C = carry out; for sub, C = no borrow.
  - V = signed overflow; N = MSB; Z = result == 0.
  - Logic ops and pass set C = V = 0.
- Flag register:
  - Loads temp_flags on an edge where in_valid && set_flags && !is_mul && state == IDLE.
  - MUL never writes flags.
- FSM states:
  - IDLE:
    - Non-mul: result = ALU output, result_valid = in_valid.
    - in_valid && is_mul: accept the mul. stall = 1, result_valid = 0. Latch forwarded A and B, clear the accumulator, set count = L. Go to BUSY.
  - BUSY:
    - stall = 1, result_valid = 0.
    - Each cycle: add the partial product of BITS_PER_CYCLE multiplier bits, shift, decrement count.
    - When count reaches 1: go to DONE.
  - DONE:
    - stall = 0, result = low WIDTH bits of the product, result_valid = 1.
    - Go to IDLE unconditionally. The held mul still sits at the inputs this cycle and must not be re-accepted.
- Product: low WIDTH bits only; identical for signed and unsigned operands.
- Forwarding sources changing during BUSY have no effect, because operands are latched at accept.
- Reset (asynchronous, any time, including mid-multiply):
  - FSM to IDLE; count, accumulator and flags to 0.
  - stall = 0, result_valid = 0.
  - result = ALU output of the current inputs.

## Timing
- Non-mul ops: zero-cycle combinational result.
- Flags visible on the flags output the cycle after the setting instruction; temp_flags are same-cycle.
- MUL accepted in cycle t0:
  - stall high in cycles t0 .. t0+L.
  - result_valid high and stall low in cycle t0+L+1; the pipeline advances at the end of t0+L+1.
  - Total occupancy L+2 cycles; WIDTH=64, BITS_PER_CYCLE=1 gives a result in t0+65.
- A mul directly following a mul: the second is accepted in the IDLE cycle after DONE.

## Structure
- Add to package structures:
  - alu_ctrl_t enum (the codes above).
  - FLAG_N/Z/V/C index constants.
  - ex_mul_state_t {IDLE, BUSY, DONE}.
- Sub-module iter_multiplier (WIDTH, BITS_PER_CYCLE):
  - Ports: start, a, b, busy, done, product.
  - Contains count and accumulator.
- Forwarding muxes, ALU, flag register and the FSM stay in ex_stage_mc.

## Test plan
- Forwarding priority: rn = 3, mem_rd = 3 and wb_rd = 3 both writing, mem = 0x10, wb = 0x20, read_data_1 = 0x30; add with B = 1 -> result = 0x11.
- XZR: rn = 31, mem_rd = 31, mem_reg_write = 1, read_data_1 = 0; add with B = 5 -> result = 5, no forward.
- Flags: sub 5 − 5 with set_flags -> temp_flags Z = 1, C = 1; flags = 4'b1010 next cycle. Following add without set_flags -> flags unchanged.
- Overflow: add 0x7FFF_FFFF_FFFF_FFFF + 1 with set_flags -> N = 1, V = 1, C = 0, Z = 0.
- MUL (WIDTH = 64, BITS_PER_CYCLE = 1):
  - 0xFFFF_FFFF_FFFF_FFFF × 3 accepted at t0 -> stall high t0..t0+64.
  - Cycle t0+65: result = 0xFFFF_FFFF_FFFF_FFFD, result_valid = 1, flags unchanged.
  - No re-accept at t0+66.
- Reset mid-MUL: assert rst at t0+20 -> stall = 0 immediately, state IDLE. After release, next add accepted normally.
